// File: rtl/fpa_norm_round_if.sv
// ---------------------------------------------------------------------------
// fpa_norm_round_if
//   Bundles the handshake and data signals around the fpa normalise/round
//   back end.
//   Input side  : in_valid, in_ready, sign, exp, mantis
//   Output side : out_valid, out_ready, result, ovf, inexact
//   master : the producer/consumer wrapped around the block (fpa + result reg)
//   slave  : the normalise/round block itself
// ---------------------------------------------------------------------------
interface fpa_norm_round_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      sign;
  logic [EXP_W-1:0]          exp;
  logic [FRAC_W+4:0]         mantis;
  logic                      out_valid;
  logic                      out_ready;
  logic [EXP_W+FRAC_W:0]     result;
  logic                      ovf;
  logic                      inexact;

  modport master (
    output in_valid, sign, exp, mantis, out_ready,
    input  in_ready, out_valid, result, ovf, inexact
  );

  modport slave (
    input  in_valid, sign, exp, mantis, out_ready,
    output in_ready, out_valid, result, ovf, inexact
  );
endinterface

// File: rtl/fpa_norm_round.sv
// ---------------------------------------------------------------------------
// fpa_norm_round
//   Back end of the fpa adder. Accepts an unnormalised {sign, exp, mantis}
//   tuple, normalises it one bit per cycle, rounds to nearest-even (or
//   truncates when ROUND_EN=0) and returns a packed IEEE-754 word.
//
//   Parameters
//     EXP_W    exponent width
//     FRAC_W   stored fraction width (mantis is FRAC_W+5 bits)
//     ROUND_EN 1 = round-to-nearest-even, 0 = truncate
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of fpa_norm_round_if:
//              in_valid/in_ready  input handshake
//              sign/exp/mantis    mantis = {carry, hidden, frac, G, R, S}
//              out_valid/out_ready output handshake
//              result             {sign, exp, frac}
//              ovf                result saturated to infinity
//              inexact            G|R|S nonzero after normalisation
// ---------------------------------------------------------------------------
module fpa_norm_round #(
  parameter int EXP_W    = 8,
  parameter int FRAC_W   = 23,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  fpa_norm_round_if.slave bus
);

  localparam int MANT_W = FRAC_W + 5;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  // Exponent is carried one bit wider than the field so a carry past the
  // all-ones code is still visible when overflow is decided.
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic                sign_reg, sign_next;
  logic [EXP_W:0]      exp_reg, exp_next;
  logic [MANT_W-1:0]   mant_reg, mant_next;
  logic                pass_reg, pass_next;   // inf/NaN input, no rounding
  logic                zero_reg, zero_next;   // all-zero mantissa
  logic [WORD_W-1:0]   result_reg, result_next;
  logic                ovf_reg, ovf_next;
  logic                inexact_reg, inexact_next;
  logic                out_valid_reg, out_valid_next;

  // ---------------------------------------------------------------------
  // Rounding datapath, evaluated on the normalised mantissa in ROUND
  // ---------------------------------------------------------------------
  logic [FRAC_W-1:0]   frac;
  logic                g_bit, r_bit, s_bit;
  logic                round_up;
  logic [FRAC_W:0]     frac_sum;
  logic [EXP_W:0]      exp_rnd;
  logic                exp_ovf;
  logic [WORD_W-1:0]   round_word;
  logic                round_ovf;
  logic                round_inexact;

  assign frac     = mant_reg[MANT_W-3:3];
  assign g_bit    = mant_reg[2];
  assign r_bit    = mant_reg[1];
  assign s_bit    = mant_reg[0];
  // Ties (G=1, R=S=0) round up only when the kept LSB is odd.
  assign round_up = ROUND_EN & g_bit & (r_bit | s_bit | frac[0]);
  assign frac_sum = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
  // A fraction carry-out leaves frac_sum[FRAC_W-1:0] at zero and bumps the
  // exponent; this also promotes an all-ones denormal to the smallest normal.
  assign exp_rnd  = exp_reg + {{EXP_W{1'b0}}, frac_sum[FRAC_W]};
  assign exp_ovf  = (exp_rnd >= EXP_MAX);

  always_comb begin
    round_word    = {sign_reg, exp_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
    round_ovf     = 1'b0;
    round_inexact = g_bit | r_bit | s_bit;
    if (pass_reg) begin
      round_word    = {sign_reg, exp_reg[EXP_W-1:0], frac};
      round_inexact = 1'b0;
    end else if (zero_reg) begin
      round_word = {sign_reg, {(WORD_W-1){1'b0}}};
    end else if (exp_ovf) begin
      round_word = {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      round_ovf  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    sign_next      = sign_reg;
    exp_next       = exp_reg;
    mant_next      = mant_reg;
    pass_next      = pass_reg;
    zero_next      = zero_reg;
    result_next    = result_reg;
    ovf_next       = ovf_reg;
    inexact_next   = inexact_reg;
    out_valid_next = out_valid_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          sign_next  = bus.sign;
          exp_next   = {1'b0, bus.exp};
          mant_next  = bus.mantis;
          pass_next  = 1'b0;
          zero_next  = 1'b0;
          state_next = NORM;
        end
      end

      NORM: begin
        if (exp_reg == EXP_MAX) begin
          pass_next  = 1'b1;
          state_next = ROUND;
        end else if (mant_reg == '0) begin
          zero_next  = 1'b1;
          state_next = ROUND;
        end else if (mant_reg[MANT_W-1]) begin
          // Carry out of the add: shift right, folding the dropped bit
          // into sticky so rounding still sees it.
          mant_next  = {1'b0, mant_reg[MANT_W-1:2], mant_reg[1] | mant_reg[0]};
          exp_next   = exp_reg + EXP_ONE;
          state_next = ROUND;
        end else if (!mant_reg[MANT_W-2] && (exp_reg > EXP_ONE)) begin
          mant_next  = {mant_reg[MANT_W-2:0], 1'b0};
          exp_next   = exp_reg - EXP_ONE;
        end else if (!mant_reg[MANT_W-2]) begin
          // Cannot shift further without going below the minimum exponent:
          // encode as a denormal with the fraction as it stands.
          exp_next   = '0;
          state_next = ROUND;
        end else begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        result_next    = round_word;
        ovf_next       = round_ovf;
        inexact_next   = round_inexact;
        out_valid_next = 1'b1;
        state_next     = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sign_reg      <= 1'b0;
      exp_reg       <= '0;
      mant_reg      <= '0;
      pass_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      result_reg    <= '0;
      ovf_reg       <= 1'b0;
      inexact_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sign_reg      <= sign_next;
      exp_reg       <= exp_next;
      mant_reg      <= mant_next;
      pass_reg      <= pass_next;
      zero_reg      <= zero_next;
      result_reg    <= result_next;
      ovf_reg       <= ovf_next;
      inexact_reg   <= inexact_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.inexact   = inexact_reg;

endmodule

// File: tb/tb_fpa_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fpa_norm_round
//   Directed bench for fpa_norm_round. dut0 rounds to nearest-even, dut1
//   truncates. Expected dut0 results are queued when a tuple is driven and
//   compared when the block hands the result over.
// ---------------------------------------------------------------------------
module tb_fpa_norm_round;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fpa_norm_round_if #(.EXP_W(8), .FRAC_W(23)) bus0 ();
  fpa_norm_round_if #(.EXP_W(8), .FRAC_W(23)) bus1 ();

  fpa_norm_round #(.EXP_W(8), .FRAC_W(23), .ROUND_EN(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fpa_norm_round #(.EXP_W(8), .FRAC_W(23), .ROUND_EN(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        inx;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare on each output handshake
  always @(negedge clk) begin
    if (rst_n && bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_output", bus0.result, 32'hxxxx_xxxx);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.tag, "_result"},  bus0.result,        mon_e.res);
        check({mon_e.tag, "_ovf"},     32'(bus0.ovf),      32'(mon_e.ovf));
        check({mon_e.tag, "_inexact"}, 32'(bus0.inexact),  32'(mon_e.inx));
        $display("txn %s: result %h ovf %0b inexact %0b", mon_e.tag, bus0.result, bus0.ovf, bus0.inexact);
      end
    end
  end

  task automatic send(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                      input bit push, input logic [31:0] r, input logic o, input logic x);
    exp_t item;
    int   n;
    @(negedge clk);
    bus0.sign     = s;
    bus0.exp      = e;
    bus0.mantis   = m;
    bus0.in_valid = 1'b1;
    if (push) begin
      item.res = r; item.ovf = o; item.inx = x; item.tag = tag;
      q.push_back(item);
    end
    n = 0;
    while (bus0.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 32'(bus0.in_ready), 32'd1);
    @(posedge clk);
    #1;
    // Garbage after acceptance must not disturb the operation in flight
    bus0.in_valid = 1'b0;
    bus0.exp      = 8'hA5;
    bus0.mantis   = 28'hFFFFFFF;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (bus0.out_valid !== 1'b1 && lat < 60);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bus0.in_ready), 32'd0);
  endtask

  task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                     input logic [31:0] r, input logic o, input logic x, input int lat);
    send(tag, s, e, m, 1'b1, r, o, x);
    wait_out(tag, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus0.in_valid = 1'b0; bus0.sign = 1'b0; bus0.exp = '0; bus0.mantis = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.sign = 1'b0; bus1.exp = '0; bus1.mantis = '0; bus1.out_ready = 1'b1;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus0.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_result",    bus0.result,         32'h0);
    check("rst_ovf",       32'(bus0.ovf),       32'd0);
    check("rst_inexact",   32'(bus0.inexact),   32'd0);
    rst_n = 1'b1;

    run("one",        1'b0, 8'h7F, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 2);
    run("carry",      1'b0, 8'h7F, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 2);
    run("ovf",        1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 2);
    run("shift4",     1'b0, 8'h80, 28'h0400000, 32'h3E000000, 1'b0, 1'b0, 6);
    run("tie_even",   1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 2);
    run("round_up",   1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 1'b0, 1'b1, 2);
    run("rnd_carry",  1'b0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b1, 2);
    run("neg_zero",   1'b1, 8'h10, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 2);
    run("denorm",     1'b0, 8'h01, 28'h2000000, 32'h00400000, 1'b0, 1'b0, 2);
    run("denorm_shf", 1'b0, 8'h02, 28'h1000000, 32'h00400000, 1'b0, 1'b0, 3);
    run("nan_pass",   1'b0, 8'hFF, 28'h4000008, 32'h7F800001, 1'b0, 1'b0, 2);

    // Back-pressure: result held while out_ready is low, new input ignored
    bus0.out_ready = 1'b0;
    send("hold", 1'b0, 8'h7F, 28'h4000000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
    wait_out("hold", 2);
    bus0.in_valid = 1'b1;
    bus0.exp      = 8'h40;
    bus0.mantis   = 28'h8000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result",    bus0.result,         32'h3F800000);
      check("hold_out_valid", 32'(bus0.out_valid), 32'd1);
      check("hold_in_ready",  32'(bus0.in_ready),  32'd0);
    end
    bus0.in_valid = 1'b0;
    @(posedge clk);
    #1 bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a multi-cycle normalisation
    send("abort", 1'b0, 8'h80, 28'h0400000, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus0.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus0.in_ready),  32'd1);
    check("abort_result",    bus0.result,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus0.out_valid === 1'b1) n++;
    end
    check("abort_no_output", 32'(n), 32'd0);
    run("recover", 1'b1, 8'h7F, 28'h4000000, 32'hBF800000, 1'b0, 1'b0, 2);

    // Truncating instance
    @(negedge clk);
    bus1.sign = 1'b0; bus1.exp = 8'h7F; bus1.mantis = 28'h7FFFFFC; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    n = 0;
    while (bus1.out_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    check("trunc_latency", 32'(n), 32'd2);
    check("trunc_result",  bus1.result,        32'h3FFFFFFF);
    check("trunc_ovf",     32'(bus1.ovf),      32'd0);
    check("trunc_inexact", 32'(bus1.inexact),  32'd1);
    $display("txn trunc: result %h ovf %0b inexact %0b", bus1.result, bus1.ovf, bus1.inexact);
    @(posedge clk);
    #1;

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
